// File: rtl/pll_reset_sequencer.sv
// PLL lock qualification and staged reset release.
// Stretches lock, checks clock frequency against ref_tick, then releases resets in order.
module pll_reset_sequencer #(
    parameter int STRETCH_CYCLES  = 1024,
    parameter int STAGE_GAP       = 16,
    parameter int NUM_STAGES      = 3,
    parameter int EXPECTED_PERIOD = 100,
    parameter int TOLERANCE       = 2,
    parameter int PASSES          = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pll_unlocked,
    input  logic                  ref_tick,
    output logic [NUM_STAGES-1:0] rst_stage,
    output logic                  ready,
    output logic [7:0]            lock_loss_count,
    output logic                  freq_fault,
    output logic [15:0]           last_period
);

    localparam int SW = $clog2(STRETCH_CYCLES + 1);
    localparam int GW = $clog2(STAGE_GAP + 1);
    localparam int PW = $clog2(PASSES + 1);
    localparam logic [15:0] PERIOD_LO = 16'(EXPECTED_PERIOD - TOLERANCE);
    localparam logic [15:0] PERIOD_HI = 16'(EXPECTED_PERIOD + TOLERANCE);

    typedef enum logic [2:0] {
        HOLD,
        STRETCH,
        FREQ_CHECK,
        RELEASE,
        RUN
    } state_t;

    state_t                  state;
    logic [SW-1:0]           stretch_cnt;
    logic [PW-1:0]           pass_cnt;
    logic [GW-1:0]           gap_cnt;
    logic [3:0]              stage_idx;
    logic [15:0]             period_cnt;
    logic                    armed;

    logic                    win_close;
    logic                    in_tol;
    logic                    bad_win;
    logic [7:0]              llc_inc;
    logic [NUM_STAGES-1:0]   keep_mask;
    logic [NUM_STAGES-1:0]   first_mask;

    // A window closes on a tick or when the counter pins at its ceiling.
    assign win_close = (state != HOLD) && armed &&
                       (ref_tick || (period_cnt == 16'hFFFF));
    assign in_tol    = (period_cnt >= PERIOD_LO) && (period_cnt <= PERIOD_HI);
    assign bad_win   = win_close && !in_tol;
    assign llc_inc   = (lock_loss_count == 8'hFF) ? lock_loss_count
                                                  : lock_loss_count + 8'd1;

    always_comb begin
        keep_mask  = '0;
        first_mask = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            keep_mask[i]  = (4'(i) > stage_idx);
            first_mask[i] = (i != 0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= HOLD;
            stretch_cnt     <= '0;
            pass_cnt        <= '0;
            gap_cnt         <= '0;
            stage_idx       <= '0;
            period_cnt      <= '0;
            armed           <= 1'b0;
            rst_stage       <= '1;
            ready           <= 1'b0;
            lock_loss_count <= '0;
            freq_fault      <= 1'b0;
            last_period     <= '0;
        end else begin
            // Counter holds cycles since the previous tick; the tick cycle itself restarts it at 1.
            if (state == HOLD) begin
                armed      <= 1'b0;
                period_cnt <= '0;
            end else if (ref_tick) begin
                armed      <= 1'b1;
                period_cnt <= 16'd1;
            end else if (armed && (period_cnt != 16'hFFFF)) begin
                period_cnt <= period_cnt + 16'd1;
            end

            if (win_close) begin
                last_period <= period_cnt;
            end

            unique case (state)
                HOLD: begin
                    rst_stage   <= '1;
                    ready       <= 1'b0;
                    stretch_cnt <= '0;
                    if (!pll_unlocked) begin
                        state <= STRETCH;
                    end
                end

                STRETCH: begin
                    if (pll_unlocked) begin
                        state       <= HOLD;
                        stretch_cnt <= '0;
                    end else if (stretch_cnt == SW'(STRETCH_CYCLES - 1)) begin
                        state    <= FREQ_CHECK;
                        pass_cnt <= '0;
                    end else begin
                        stretch_cnt <= stretch_cnt + 1'b1;
                    end
                end

                FREQ_CHECK: begin
                    if (pll_unlocked) begin
                        state <= HOLD;
                    end else if (win_close) begin
                        if (!in_tol) begin
                            pass_cnt <= '0;
                        end else if (pass_cnt == PW'(PASSES - 1)) begin
                            state     <= RELEASE;
                            rst_stage <= first_mask;
                            gap_cnt   <= '0;
                            stage_idx <= 4'd1;
                        end else begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                end

                RELEASE: begin
                    if (pll_unlocked) begin
                        state           <= HOLD;
                        rst_stage       <= '1;
                        ready           <= 1'b0;
                        lock_loss_count <= llc_inc;
                    end else if (gap_cnt == GW'(STAGE_GAP - 1)) begin
                        gap_cnt <= '0;
                        if (stage_idx == 4'(NUM_STAGES)) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end else begin
                            rst_stage <= rst_stage & keep_mask;
                            stage_idx <= stage_idx + 4'd1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                RUN: begin
                    if (pll_unlocked || bad_win) begin
                        state     <= HOLD;
                        rst_stage <= '1;
                        ready     <= 1'b0;
                    end
                    if (pll_unlocked) begin
                        lock_loss_count <= llc_inc;
                    end
                    if (bad_win) begin
                        freq_fault <= 1'b1;
                    end
                end

                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: two instances run side by side,
// one for bring-up/tolerance/lock-loss/reset cases, one for counter saturation.
module tb_pll_reset_sequencer;

    localparam int NS = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic rst_i  [2];
    logic unl_i  [2];
    logic tick_i [2];

    logic [NS-1:0] rs_a, rs_b;
    logic          rdy_a, rdy_b;
    logic [7:0]    llc_a, llc_b;
    logic          ff_a, ff_b;
    logic [15:0]   lp_a, lp_b;

    pll_reset_sequencer #(
        .STRETCH_CYCLES(8), .STAGE_GAP(4), .NUM_STAGES(NS),
        .EXPECTED_PERIOD(100), .TOLERANCE(2), .PASSES(2)
    ) dut_a (
        .clock(clock), .reset(rst_i[0]), .pll_unlocked(unl_i[0]),
        .ref_tick(tick_i[0]), .rst_stage(rs_a), .ready(rdy_a),
        .lock_loss_count(llc_a), .freq_fault(ff_a), .last_period(lp_a)
    );

    pll_reset_sequencer #(
        .STRETCH_CYCLES(8), .STAGE_GAP(4), .NUM_STAGES(NS),
        .EXPECTED_PERIOD(100), .TOLERANCE(2), .PASSES(2)
    ) dut_b (
        .clock(clock), .reset(rst_i[1]), .pll_unlocked(unl_i[1]),
        .ref_tick(tick_i[1]), .rst_stage(rs_b), .ready(rdy_b),
        .lock_loss_count(llc_b), .freq_fault(ff_b), .last_period(lp_b)
    );

    typedef struct {
        int            at;
        string         nm;
        logic [NS-1:0] rs;
        logic          rdy;
        logic [7:0]    llc;
        logic          ff;
        logic [15:0]   lp;
        bit            chk_lp;
    } exp_t;

    typedef struct {
        int            off;
        logic [NS-1:0] rs;
        logic          rdy;
    } rel_t;

    typedef struct {
        int            per;
        logic [NS-1:0] rs;
    } tol_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    rel_t rel_tab[7];
    tol_t tol_tab[9];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void push(input int d, input int dt, input string nm,
                                 input logic [NS-1:0] rs, input logic rdy,
                                 input logic [7:0] llc, input logic ff,
                                 input logic [15:0] lp, input bit chk_lp);
        exp_t e;
        e.at = cyc + dt; e.nm = nm; e.rs = rs; e.rdy = rdy;
        e.llc = llc; e.ff = ff; e.lp = lp; e.chk_lp = chk_lp;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endfunction

    function automatic void cmp(input exp_t e, input string who,
                                input logic [NS-1:0] rs, input logic rdy,
                                input logic [7:0] llc, input logic ff,
                                input logic [15:0] lp);
        bit bad;
        n_tests++;
        bad = (e.at != cyc) || (rs !== e.rs) || (rdy !== e.rdy) ||
              (llc !== e.llc) || (ff !== e.ff) || (e.chk_lp && (lp !== e.lp));
        if (bad) begin
            n_fail++;
            $display("FAIL %s.%s cyc=%0d(at %0d) got rs=%b rdy=%b llc=%0d ff=%b lp=%0d want rs=%b rdy=%b llc=%0d ff=%b lp=%0d",
                     who, e.nm, cyc, e.at, rs, rdy, llc, ff, lp,
                     e.rs, e.rdy, e.llc, e.ff, e.lp);
        end
    endfunction

    always @(negedge clock) begin
        while (qa.size() > 0 && qa[0].at <= cyc) begin
            ea = qa.pop_front();
            cmp(ea, "A", rs_a, rdy_a, llc_a, ff_a, lp_a);
        end
        while (qb.size() > 0 && qb[0].at <= cyc) begin
            eb = qb.pop_front();
            cmp(eb, "B", rs_b, rdy_b, llc_b, ff_b, lp_b);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic tick_after(input int d, input int n);
        step(n - 1);
        tick_i[d] = 1'b1;
        step(1);
        tick_i[d] = 1'b0;
    endtask

    // From HOLD: stretch, arm on first FREQ_CHECK cycle, two windows, release.
    task automatic bring_up(input int d, input int p1, input int p2,
                            input logic [7:0] llc, input logic ff,
                            input bit to_run);
        unl_i[d] = 1'b0;
        step(1);
        push(d, 0, "stretch", 3'b111, 1'b0, llc, ff, 16'd0, 1'b0);
        tick_after(d, 9);
        push(d, 0, "arm", 3'b111, 1'b0, llc, ff, 16'd0, 1'b0);
        tick_after(d, p1);
        push(d, 0, "win1", 3'b111, 1'b0, llc, ff, 16'(p1), 1'b1);
        tick_after(d, p2);
        if (to_run) begin
            for (int k = 0; k < 7; k++)
                push(d, rel_tab[k].off, "release", rel_tab[k].rs,
                     rel_tab[k].rdy, llc, ff, 16'(p2), 1'b1);
            step(12);
        end else begin
            push(d, 0, "release0", 3'b110, 1'b0, llc, ff, 16'(p2), 1'b1);
        end
    endtask

    task automatic proc_a();
        logic [7:0] el;
        rst_i[0] = 1'b1; unl_i[0] = 1'b0; tick_i[0] = 1'b0;
        step(2);
        push(0, 0, "reset", 3'b111, 1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
        rst_i[0] = 1'b0;
        bring_up(0, 100, 100, 8'd0, 1'b0, 1'b1);

        rst_i[0] = 1'b1; unl_i[0] = 1'b1;
        step(2);
        push(0, 0, "reset2", 3'b111, 1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
        rst_i[0] = 1'b0;
        step(1);
        push(0, 0, "hold", 3'b111, 1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
        unl_i[0] = 1'b0;
        step(6);
        unl_i[0] = 1'b1;
        step(1);
        push(0, 0, "glitch", 3'b111, 1'b0, 8'd0, 1'b0, 16'd0, 1'b1);

        unl_i[0] = 1'b0;
        step(1);
        tick_after(0, 9);
        for (int k = 0; k < 9; k++) begin
            tick_after(0, tol_tab[k].per);
            push(0, 0, "tol", tol_tab[k].rs, 1'b0, 8'd0, 1'b0,
                 16'(tol_tab[k].per), 1'b1);
        end
        for (int k = 0; k < 7; k++)
            push(0, rel_tab[k].off, "tol_release", rel_tab[k].rs,
                 rel_tab[k].rdy, 8'd0, 1'b0, 16'd100, 1'b1);
        step(12);

        for (int i = 0; i < 260; i++) begin
            el = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            unl_i[0] = 1'b1;
            step(1);
            push(0, 0, "lockloss", 3'b111, 1'b0, el, 1'b0, 16'd100, 1'b1);
            step(9);
            push(0, 0, "lockloss_held", 3'b111, 1'b0, el, 1'b0, 16'd100, 1'b1);
            bring_up(0, 100, 100, el, 1'b0, i != 259);
        end

        rst_i[0] = 1'b1; unl_i[0] = 1'b1;
        step(1);
        push(0, 0, "reset_vs_loss", 3'b111, 1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
        rst_i[0] = 1'b0;
        step(1);
        push(0, 0, "hold_after", 3'b111, 1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
        step(1);
    endtask

    task automatic proc_b();
        rst_i[1] = 1'b1; unl_i[1] = 1'b0; tick_i[1] = 1'b0;
        step(2);
        push(1, 0, "reset", 3'b111, 1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
        rst_i[1] = 1'b0;
        bring_up(1, 99, 101, 8'd0, 1'b0, 1'b1);
        step(65522);
        push(1, 0, "pre_sat", 3'b000, 1'b1, 8'd0, 1'b0, 16'd101, 1'b1);
        step(1);
        push(1, 0, "sat", 3'b111, 1'b0, 8'd0, 1'b1, 16'hFFFF, 1'b1);
        bring_up(1, 100, 100, 8'd0, 1'b1, 1'b1);
        rst_i[1] = 1'b1;
        step(1);
        push(1, 0, "fault_clear", 3'b111, 1'b0, 8'd0, 1'b0, 16'd0, 1'b1);
        rst_i[1] = 1'b0;
        step(1);
    endtask

    initial begin
        rel_tab[0] = '{0,  3'b110, 1'b0};
        rel_tab[1] = '{3,  3'b110, 1'b0};
        rel_tab[2] = '{4,  3'b100, 1'b0};
        rel_tab[3] = '{7,  3'b100, 1'b0};
        rel_tab[4] = '{8,  3'b000, 1'b0};
        rel_tab[5] = '{11, 3'b000, 1'b0};
        rel_tab[6] = '{12, 3'b000, 1'b1};
        tol_tab[0] = '{98,  3'b111};
        tol_tab[1] = '{103, 3'b111};
        tol_tab[2] = '{102, 3'b111};
        tol_tab[3] = '{103, 3'b111};
        tol_tab[4] = '{97,  3'b111};
        tol_tab[5] = '{100, 3'b111};
        tol_tab[6] = '{104, 3'b111};
        tol_tab[7] = '{101, 3'b111};
        tol_tab[8] = '{100, 3'b110};
        for (int d = 0; d < 2; d++) begin
            rst_i[d] = 1'b1; unl_i[d] = 1'b1; tick_i[d] = 1'b0;
        end
        step(1);
        fork
            proc_a();
            proc_b();
        join
        step(2);
        if (qa.size() + qb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_leftover pending=%0d want 0", qa.size() + qb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d want finish before limit", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
